train_target_seq: RTL and testbench

- Parametrised successor to the single-channel target-value memory used by the backpropagation network.
- Holds NUM_SAMPLES training patterns of NUM_CH fixed-point targets each, loadable at run time through a write port.
- Steps through the patterns itself, presenting one pattern per valid/ready handshake to the error/delta stage, and counts epochs.
- Replaces the externally addressed, tri-stated read with a self-sequenced, registered, handshaked output.

---
 rtl/train_target_seq.sv | 210 +++++++++++++++++++++
 tb/tb_train_target_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/train_target_seq.sv
// -----------------------------------------------------------------------------
// train_target_seq
//
// Purpose:
//   Run-time loadable target-value store for the backpropagation network.
//   Holds NUM_SAMPLES patterns of NUM_CH fixed-point targets. It steps through
//   the patterns by itself and presents one pattern per valid/ready handshake
//   to the error/delta stage. It also counts completed epochs.
//   Stored words are unsigned 8.24. Each output channel is the slice
//   stored[OUT_LSB+DWIDTH-1:OUT_LSB], with truncation and no rounding.
//
// Optional feature (compile-time macro TGT_SAT_EN):
//   defined     - any stored bit above the output slice forces that channel
//                 to all ones (saturation).
//   not defined - plain slice; overflow bits are dropped.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   wr_en       in   pattern memory write strobe (legal in any state)
//   wr_addr     in   word address = sample*NUM_CH + ch; out-of-range ignored
//   wr_data     in   stored target value, 8.24
//   start       in   one-cycle pulse, begins sequencing at sample 0 (IDLE only)
//   stop        in   synchronous abort, priority over start and handshake
//   out_ready   in   consumer accepts the presented pattern
//   out_valid   out  out_data holds a valid pattern
//   out_data    out  channel ch at bits [ch*DWIDTH +: DWIDTH]
//   sample_idx  out  index of the presented pattern
//   epoch_cnt   out  epochs completed since the last start
//   epoch_done  out  one-cycle pulse after the last sample of an epoch is accepted
//   busy        out  sequencer not idle
// -----------------------------------------------------------------------------
module train_target_seq #(
   parameter int DWIDTH      = 16,
   parameter int SWIDTH      = 32,
   parameter int OUT_LSB     = 14,
   parameter int NUM_CH      = 2,
   parameter int NUM_SAMPLES = 4,
   parameter int AWIDTH      = 4,
   parameter int NUM_EPOCHS  = 0,
   parameter int EWIDTH      = 16,
   localparam int IWIDTH     = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [AWIDTH-1:0]        wr_addr,
   input  logic [SWIDTH-1:0]        wr_data,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [NUM_CH*DWIDTH-1:0] out_data,
   output logic [IWIDTH-1:0]        sample_idx,
   output logic [EWIDTH-1:0]        epoch_cnt,
   output logic                     epoch_done,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     state_nxt;
   logic [SWIDTH-1:0]          mem_r [NUM_SAMPLES][NUM_CH];
   logic [NUM_CH*DWIDTH-1:0]   fetch_s;
   logic [NUM_CH*DWIDTH-1:0]   out_data_r;
   logic [IWIDTH-1:0]          sample_idx_r;
   logic [EWIDTH-1:0]          epoch_cnt_r;
   logic [EWIDTH-1:0]          epoch_inc_s;
   logic                       out_valid_r;
   logic                       epoch_done_r;
   logic                       busy_r;
   logic                       handshake_s;
   logic                       last_s;
   logic                       epochs_hit_s;
   logic                       start_acc_s;
   logic                       stop_acc_s;
   logic                       advance_s;
   logic                       wrap_s;

   // Stored 8.24 word to output format, with optional overflow saturation.
   function automatic logic [DWIDTH-1:0] conv_word(input logic [SWIDTH-1:0] word);
      logic [DWIDTH-1:0] slice;
      slice = word[OUT_LSB +: DWIDTH];
`ifdef TGT_SAT_EN
      return ((word >> (OUT_LSB + DWIDTH)) != {SWIDTH{1'b0}}) ? {DWIDTH{1'b1}} : slice;
`else
      return slice;
`endif
   endfunction

   // Convert every channel of the currently indexed sample.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_fetch
      assign fetch_s[c*DWIDTH +: DWIDTH] = conv_word(mem_r[sample_idx_r][c]);
   end

   // Pattern memory: cleared on reset, written whenever wr_en hits a valid word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SAMPLES; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               mem_r[s][c] <= {SWIDTH{1'b0}};
            end
         end
      end else begin
         for (int s = 0; s < NUM_SAMPLES; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (wr_en && (32'(wr_addr) == 32'(s*NUM_CH + c))) begin
                  mem_r[s][c] <= wr_data;
               end
            end
         end
      end
   end

   // Next-state logic and the one-cycle control strobes that drive the registers.
   always_comb begin
      state_nxt    = state_r;
      start_acc_s  = 1'b0;
      advance_s    = 1'b0;
      wrap_s       = 1'b0;
      handshake_s  = out_valid_r && out_ready;
      last_s       = (sample_idx_r == IWIDTH'(NUM_SAMPLES - 1));
      epoch_inc_s  = epoch_cnt_r + EWIDTH'(1);
      epochs_hit_s = (NUM_EPOCHS != 32'sd0) && (epoch_inc_s == EWIDTH'(NUM_EPOCHS));
      stop_acc_s   = stop && (state_r != IDLE);
      case (state_r)
         IDLE: begin
            if (start && !stop) begin
               state_nxt   = FETCH;
               start_acc_s = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         FETCH: begin
            if (stop) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (handshake_s && last_s) begin
               wrap_s    = 1'b1;
               state_nxt = epochs_hit_s ? DONE : FETCH;
            end else if (handshake_s) begin
               advance_s = 1'b1;
               state_nxt = FETCH;
            end else begin
               state_nxt = PRESENT;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, handshake and counter registers; all outputs come from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         out_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         epoch_done_r <= 1'b0;
         out_data_r   <= {(NUM_CH*DWIDTH){1'b0}};
         sample_idx_r <= {IWIDTH{1'b0}};
         epoch_cnt_r  <= {EWIDTH{1'b0}};
      end else begin
         state_r      <= state_nxt;
         out_valid_r  <= (state_nxt == PRESENT);
         busy_r       <= (state_nxt != IDLE);
         epoch_done_r <= wrap_s;
         // Capture happens once per FETCH, so later writes never disturb a
         // presented pattern and a same-cycle write is not seen.
         if ((state_r == FETCH) && (state_nxt == PRESENT)) begin
            out_data_r <= fetch_s;
         end
         if (start_acc_s || stop_acc_s || wrap_s) begin
            sample_idx_r <= {IWIDTH{1'b0}};
         end else if (advance_s) begin
            sample_idx_r <= sample_idx_r + IWIDTH'(1);
         end
         if (start_acc_s) begin
            epoch_cnt_r <= {EWIDTH{1'b0}};
         end else if (wrap_s) begin
            epoch_cnt_r <= epoch_inc_s;
         end
      end
   end

   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign sample_idx = sample_idx_r;
   assign epoch_cnt  = epoch_cnt_r;
   assign epoch_done = epoch_done_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_train_target_seq.sv
// -----------------------------------------------------------------------------
// tb_train_target_seq
//
// Directed bench for train_target_seq. Expected patterns come from a bench-side
// memory model and are queued when the stimulus that causes them is driven.
// They are popped and compared when the DUT presents a pattern.
// Instance "dut" runs free (NUM_EPOCHS = 0). Instance "dut_b" stops after two
// epochs.
// -----------------------------------------------------------------------------
module tb_train_target_seq;

   localparam int DW  = 16;
   localparam int SW  = 32;
   localparam int OL  = 14;
   localparam int NCH = 2;
   localparam int NS  = 4;
   localparam int AW  = 4;
   localparam int EW  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [SW-1:0]     wr_data = '0;
   logic              start = 1'b0;
   logic              start_b = 1'b0;
   logic              stop = 1'b0;
   logic              out_ready = 1'b0;

   logic              out_valid, epoch_done, busy;
   logic [NCH*DW-1:0] out_data;
   logic [1:0]        sample_idx;
   logic [EW-1:0]     epoch_cnt;

   logic              b_out_valid, b_epoch_done, b_busy;
   logic [NCH*DW-1:0] b_out_data;
   logic [1:0]        b_sample_idx;
   logic [EW-1:0]     b_epoch_cnt;

   train_target_seq dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .sample_idx(sample_idx),
      .epoch_cnt(epoch_cnt), .epoch_done(epoch_done), .busy(busy)
   );

   train_target_seq #(.NUM_EPOCHS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start_b), .stop(stop), .out_ready(out_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .sample_idx(b_sample_idx),
      .epoch_cnt(b_epoch_cnt), .epoch_done(b_epoch_done), .busy(b_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]        idx;
      logic [NCH*DW-1:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [SW-1:0] model_mem [NS*NCH];
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [DW-1:0] exp_conv(input logic [SW-1:0] w);
      logic [DW-1:0] v;
      v = w[OL +: DW];
`ifdef TGT_SAT_EN
      if (w[SW-1:OL+DW] != '0) v = '1;
`endif
      return v;
   endfunction

   function automatic logic [NCH*DW-1:0] model_row(input int s);
      logic [NCH*DW-1:0] r;
      for (int c = 0; c < NCH; c++) r[c*DW +: DW] = exp_conv(model_mem[s*NCH + c]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int a, input logic [SW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      step();
      wr_en = 1'b0;
      if (a < NS*NCH) model_mem[a] = d;
   endtask

   task automatic push_exp(input int s);
      exp_t e;
      e.idx  = 2'(s);
      e.data = model_row(s);
      exp_q.push_back(e);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
   endtask

   // Pattern is presented and out_ready is high: compare, queue the next
   // expected pattern, let the handshake happen, then check the bubble cycle.
   task automatic take(input string tag, input int next_s, input bit last);
      exp_t e;
      e = '0;
      n_checks++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_queue: observed empty expected entry", tag);
      end
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_idx"}, 64'(sample_idx), 64'(e.idx));
      chk({tag, "_data"}, 64'(out_data), 64'(e.data));
      if (next_s >= 0) push_exp(next_s);
      step();
      chk({tag, "_bubble"}, 64'(out_valid), 64'd0);
      chk({tag, "_edone"}, 64'(epoch_done), 64'(last));
   endtask

   initial begin
      int hs;
      int nb;
      int edc;
      int extra;
      for (int i = 0; i < NS*NCH; i++) model_mem[i] = '0;

      // Reset state
      step();
      step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_idx", 64'(sample_idx), 64'd0);
      chk("rst_epoch", 64'(epoch_cnt), 64'd0);
      chk("rst_edone", 64'(epoch_done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      step();

      // Load patterns and run one epoch with out_ready held high
      for (int s = 0; s < NS; s++) begin
         write_word(s*NCH,     (s == 0) ? 32'h0000_0000 : 32'h0100_0000);
         write_word(s*NCH + 1, (s == 2) ? 32'h0100_0000 : 32'h0000_0000);
      end
      out_ready = 1'b1;
      start = 1'b1;
      push_exp(0);
      step();
      start = 1'b0;
      chk("lat_fetch_valid", 64'(out_valid), 64'd0);
      chk("lat_fetch_busy", 64'(busy), 64'd1);
      step();
      chk("lat_present_valid", 64'(out_valid), 64'd1);
      chk("ep1_cnt0", 64'(epoch_cnt), 64'd0);
      for (int s = 0; s < NS; s++) begin
         wait_valid("ep1");
         take("ep1", (s + 1) % NS, s == NS - 1);
      end
      chk("ep1_cnt", 64'(epoch_cnt), 64'd1);

      // Back-pressure on sample 1 while it is rewritten
      wait_valid("ep2s0");
      take("ep2s0", 1, 1'b0);
      wait_valid("ep2s1");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            wr_en   = 1'b1;
            wr_addr = AW'(2);
            wr_data = 32'h0280_0000;
         end
         step();
         wr_en = 1'b0;
         if (i == 2) model_mem[2] = 32'h0280_0000;
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_idx", 64'(sample_idx), 64'(exp_q[0].idx));
         chk("hold_data", 64'(out_data), 64'(exp_q[0].data));
      end
      out_ready = 1'b1;
      for (int s = 1; s < NS; s++) begin
         wait_valid("ep2");
         take("ep2", (s + 1) % NS, s == NS - 1);
      end
      chk("ep2_cnt", 64'(epoch_cnt), 64'd2);
      wait_valid("ep3s0");
      take("ep3s0", 1, 1'b0);
      wait_valid("ep3s1");
      take("ep3s1_new", 2, 1'b0);
      wait_valid("ep3s2");

      // Stop at sample 2 together with a start that must be ignored
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      exp_q.delete();
      chk("stop_valid", 64'(out_valid), 64'd0);
      chk("stop_idx", 64'(sample_idx), 64'd0);
      chk("stop_busy", 64'(busy), 64'd0);
      chk("stop_epoch", 64'(epoch_cnt), 64'd2);
      chk("stop_edone", 64'(epoch_done), 64'd0);
      step();
      chk("stop_start_ignored", 64'(busy), 64'd0);

      // Overflow and truncation on sample 0, then restart from sample 0
      write_word(0, 32'h4000_0000);
      write_word(1, 32'h0000_3FFF);
      start = 1'b1;
      push_exp(0);
      step();
      start = 1'b0;
      chk("restart_epoch", 64'(epoch_cnt), 64'd0);
      chk("restart_idx", 64'(sample_idx), 64'd0);
      wait_valid("conv");
      take("conv", 1, 1'b0);
      wait_valid("pre_rst");

      // Asynchronous reset between clock edges while presenting
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_idx", 64'(sample_idx), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      #3;
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NS*NCH; i++) model_mem[i] = '0;
      step();
      write_word(15, 32'hFFFF_FFFF);
      start = 1'b1;
      push_exp(0);
      step();
      start = 1'b0;
      for (int s = 0; s < NS; s++) begin
         wait_valid("zero");
         take("zero", (s + 1) % NS, s == NS - 1);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      exp_q.delete();
      chk("zero_stop_busy", 64'(busy), 64'd0);

      // Two-epoch instance runs freely and then stays idle
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      hs = 0;
      nb = 0;
      edc = 0;
      while (hs < 2*NS && nb < 100) begin
         if (b_epoch_done) edc++;
         if (b_out_valid) begin
            chk("b_idx", 64'(b_sample_idx), 64'(hs % NS));
            hs++;
         end
         step();
         nb++;
      end
      chk("b_handshakes", 64'(hs), 64'(2*NS));
      chk("b_mid_edone", 64'(edc), 64'd1);
      chk("b_done_busy", 64'(b_busy), 64'd1);
      chk("b_done_valid", 64'(b_out_valid), 64'd0);
      chk("b_done_edone", 64'(b_epoch_done), 64'd1);
      chk("b_epoch", 64'(b_epoch_cnt), 64'd2);
      step();
      chk("b_idle_busy", 64'(b_busy), 64'd0);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         if (b_out_valid) extra++;
         step();
      end
      chk("b_no_more_valid", 64'(extra), 64'd0);
      chk("b_epoch_held", 64'(b_epoch_cnt), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
